// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// funct3 encodings, FSM state type, default sizes and operand-signedness helpers.
package mdu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ITER_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, followed by a sign-fix cycle. Constant latency for all funct3.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(ITER + 1);

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [2:0]          funct3_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     mcand_reg;
  logic                neg_reg;
  logic                div0_reg;
  logic                valid_reg;
  logic [XLEN-1:0]     result_reg;

  logic                sign1_next, sign2_next;
  logic [XLEN-1:0]     mag1_next, mag2_next;
  logic [2*XLEN-1:0]   acc_next;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, result_next;

  // Operand magnitudes for the request currently on the inputs (used only at acceptance).
  always_comb begin
    sign1_next = rs1_signed(i_funct3) & i_op1[XLEN-1];
    sign2_next = rs2_signed(i_funct3) & i_op2[XLEN-1];
    mag1_next  = sign1_next ? (XLEN'(0) - i_op1) : i_op1;
    mag2_next  = sign2_next ? (XLEN'(0) - i_op2) : i_op2;
  end

  // One iteration step. Multiply keeps the multiplier in the low half and shifts the
  // partial product in from the top; divide keeps remainder high, quotient low.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    acc_next  = {mul_sum, acc_reg[XLEN-1:1]};
    if (is_div(funct3_reg)) begin
      if (!div_diff[XLEN])
        acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      else
        acc_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix    = neg_reg ? ((2*XLEN)'(0) - acc_reg) : acc_reg;
    quo_fix     = neg_reg ? (XLEN'(0) - acc_reg[XLEN-1:0]) : acc_reg[XLEN-1:0];
    rem_fix     = neg_reg ? (XLEN'(0) - acc_reg[2*XLEN-1:XLEN]) : acc_reg[2*XLEN-1:XLEN];
    result_next = rem_fix;
    case (funct3_reg)
      F3_MUL:                         result_next = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   result_next = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                result_next = div0_reg ? '1 : quo_fix;
      default:                        result_next = rem_fix;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      funct3_reg <= F3_MUL;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      neg_reg    <= 1'b0;
      div0_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (i_flush) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (i_valid) begin
              funct3_reg <= i_funct3;
              cnt_reg    <= '0;
              div0_reg   <= (i_op2 == '0);
              neg_reg    <= (i_funct3 == F3_REM) ? sign1_next : (sign1_next ^ sign2_next);
              if (is_div(i_funct3)) begin
                acc_reg   <= {{XLEN{1'b0}}, mag1_next};
                mcand_reg <= mag2_next;
              end else begin
                acc_reg   <= {{XLEN{1'b0}}, mag2_next};
                mcand_reg <= mag1_next;
              end
              state_reg <= ST_CALC;
            end
          end
          // The counter reaches ITER after the last step; that terminal CALC edge only hands off to FIX.
          ST_CALC: begin
            if (cnt_reg == CW'(ITER)) begin
              state_reg <= ST_FIX;
            end else begin
              acc_reg <= acc_next;
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_FIX: begin
            result_reg <= result_next;
            valid_reg  <= 1'b1;
            state_reg  <= ST_DONE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_ready  = (state_reg == ST_IDLE);
  assign o_stall  = (state_reg == ST_CALC) || (state_reg == ST_FIX);
  assign o_valid  = valid_reg;
  assign o_result = result_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: expected results queued at issue, compared when
// o_valid fires, plus latency, flush, busy-ignore and mid-operation reset checks.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int ITER = 32;
  localparam int LAT  = ITER + 3;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic [2:0]      i_funct3 = 3'b000;
  logic [XLEN-1:0] i_op1 = '0;
  logic [XLEN-1:0] i_op2 = '0;
  logic            i_flush = 1'b0;
  logic            o_ready, o_stall, o_valid;
  logic [XLEN-1:0] o_result;

  int passed = 0;
  int total  = 0;
  logic [XLEN-1:0] sb_q[$];

  mdu_sequencer #(.XLEN(XLEN), .ITER(ITER)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_funct3(i_funct3),
    .i_op1(i_op1), .i_op2(i_op2), .i_flush(i_flush), .o_ready(o_ready),
    .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Count cycles from acceptance until o_valid; returns the cycle index of o_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 4 * LAT) begin
      step();
      lat++;
    end
  endtask

  task automatic no_valid_window(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      step();
      if (o_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    int lat;
    logic [XLEN-1:0] want;
    chk({tag, "_ready"}, o_ready, 1);
    sb_q.push_back(exp);
    i_funct3 = f3; i_op1 = a; i_op2 = b; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_op1 = $urandom; i_op2 = $urandom; i_funct3 = 3'($urandom_range(0, 7));
    chk({tag, "_stall"}, o_stall, 1);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, LAT);
    want = sb_q.pop_front();
    chk({tag, "_result"}, o_result, want);
    $display("op %s f3=%0d a=%h b=%h result=%h latency=%0d", tag, f3, a, b, o_result, lat);
    step();
    chk({tag, "_pulse"}, {o_valid, o_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int accepted;
    logic [XLEN-1:0] held;

    // Reset values
    i_rst_n = 1'b0;
    step(); step();
    chk("rst_result", o_result, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_ready", o_ready, 1);
    i_rst_n = 1'b1;
    step();

    run_op("mul_7x6",     F3_MUL,    32'd7,        32'd6,        32'h0000002A);
    run_op("mulh_m1m1",   F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_op("mulhu_ffff",  F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_m1x2", F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    run_op("mul_neg",     F3_MUL,    32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD);
    run_op("div_m7_2",    F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_op("rem_m7_2",    F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_op("div_7_m2",    F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    run_op("rem_7_m2",    F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001);
    run_op("divu_by0",    F3_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF);
    run_op("remu_by0",    F3_REMU,   32'd100,      32'd0,        32'd100);
    run_op("div_ovf",     F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",     F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    run_op("divu_big",    F3_DIVU,   32'hFFFFFFF0, 32'd16,       32'h0FFFFFFF);

    // Flush 10 cycles after acceptance: no result, back to idle, result held.
    held = o_result;
    i_funct3 = F3_MUL; i_op1 = 32'd5; i_op2 = 32'd5; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (9) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_ready", o_ready, 1);
    chk("flush_valid", o_valid, 0);
    chk("flush_result", o_result, held);
    $display("flush after 10 cycles: ready=%0b result=%h", o_ready, o_result);
    no_valid_window("flush_no_valid", LAT + 3);

    // Flush coincident with a request in IDLE: nothing accepted.
    i_funct3 = F3_MUL; i_op1 = 32'd2; i_op2 = 32'd2; i_valid = 1'b1; i_flush = 1'b1;
    step();
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_wins_ready", o_ready, 1);
    chk("flush_wins_stall", o_stall, 0);
    no_valid_window("flush_wins_no_valid", LAT + 3);

    // i_valid held high while busy with changing operands: exactly one acceptance.
    sb_q.push_back(32'd6);
    i_funct3 = F3_MUL; i_op1 = 32'd2; i_op2 = 32'd3; i_valid = 1'b1;
    step();
    lat = 1;
    while (!o_valid && lat < 4 * LAT) begin
      i_op1 = $urandom; i_op2 = $urandom;
      step();
      lat++;
    end
    i_valid = 1'b0;
    chk("hold_latency", lat, LAT);
    chk("hold_result", o_result, sb_q.pop_front());
    $display("held-valid op result=%h latency=%0d", o_result, lat);
    accepted = 0;
    repeat (LAT + 3) begin
      step();
      if (o_valid || o_stall) accepted++;
    end
    chk("hold_single_accept", accepted, 0);

    // Reset pulse mid-CALC discards the op, then a fresh MUL completes normally.
    i_funct3 = F3_MUL; i_op1 = 32'd4; i_op2 = 32'd4; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (5) step();
    chk("midrst_in_calc", o_stall, 1);
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    chk("midrst_result", o_result, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_stall", o_stall, 0);
    chk("midrst_ready", o_ready, 1);
    $display("reset mid-CALC: ready=%0b stall=%0b result=%h", o_ready, o_stall, o_result);
    no_valid_window("midrst_no_valid", LAT + 3);
    run_op("mul_3x3_after_rst", F3_MUL, 32'd3, 32'd3, 32'd9);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
